// File: rtl/ascon_absorb_ctrl_if.sv
// Upstream 128-bit block stream between the input buffer and the absorb sequencer.
// The source drives valid/data and the sink drives ready.
interface ascon_absorb_ctrl_if;
  logic         blk_valid;
  logic [127:0] blk_data;
  logic         blk_ready;

  modport master (output blk_valid, output blk_data, input  blk_ready);
  modport slave  (input  blk_valid, input  blk_data, output blk_ready);
endinterface

// File: rtl/ascon_absorb_ctrl.sv
// Ascon AD/message absorb sequencer: fetches rate blocks and steps the absorb
// datapath once per iteration, spacing process_en pulses by PERM_LAT cycles.
module ascon_absorb_ctrl #(
  parameter int unsigned PERM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          sel_type_i,
  input  logic [31:0]         data_length_i,
  ascon_absorb_ctrl_if.slave  blk,
  output logic                process_en,
  output logic [1:0]          sel_type,
  output logic [31:0]         data_length,
  output logic [31:0]         data_position,
  output logic [127:0]        data,
  output logic                state_sel,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FIRE,
    S_SETTLE,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(PERM_LAT - 1);

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic         r_process_en;
  logic [1:0]   r_sel_type;
  logic [31:0]  r_data_length;
  logic [31:0]  r_data_position;
  logic [127:0] r_data;
  logic         r_state_sel;
  logic         r_busy;
  logic         r_done;
  logic         r_blk_ready;

  logic [31:0]  w_rate;
  logic [31:0]  w_lmp;
  logic         w_last;
  logic         w_leave;
  logic         w_hs;

  assign w_rate  = (r_sel_type == 2'b00) ? 32'd16 : 32'd8;
  assign w_lmp   = r_data_length - r_data_position;
  assign w_last  = (w_lmp < w_rate);
  assign w_hs    = blk.blk_valid & r_blk_ready;
  // An iteration ends in FIRE when there is no settle time, else on the last SETTLE cycle.
  assign w_leave = ((r_state == S_FIRE) && (PERM_LAT == 32'd1)) ||
                   ((r_state == S_SETTLE) && (r_cnt == 4'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= 4'd0;
      r_process_en    <= 1'b0;
      r_sel_type      <= 2'b00;
      r_data_length   <= 32'd0;
      r_data_position <= 32'd0;
      r_data          <= 128'd0;
      r_state_sel     <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_blk_ready     <= 1'b0;
    end else begin
      // NOTE: strobes default low here so every path that does not raise them yields a one-cycle pulse.
      r_process_en <= 1'b0;
      r_done       <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sel_type      <= sel_type_i;
            r_data_length   <= data_length_i;
            r_data_position <= 32'd0;
            r_state_sel     <= 1'b0;
            r_busy          <= 1'b1;
            r_blk_ready     <= (data_length_i != 32'd0);
            r_state         <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_lmp == 32'd0) begin
            r_data       <= 128'd0;
            r_process_en <= 1'b1;
            r_state      <= S_FIRE;
          end else if (w_hs) begin
            r_data       <= blk.blk_data;
            r_blk_ready  <= 1'b0;
            r_process_en <= 1'b1;
            r_state      <= S_FIRE;
          end
        end
        S_FIRE: begin
          if (PERM_LAT > 32'd1) begin
            r_cnt   <= SETTLE_INIT;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          r_cnt <= r_cnt - 4'd1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // End of iteration overrides the per-state next state chosen above.
      if (w_leave) begin
        if (w_last) begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end else begin
          r_data_position <= r_data_position + w_rate;
          r_state_sel     <= 1'b1;
          r_blk_ready     <= (w_lmp != w_rate);
          r_state         <= S_LOAD;
        end
      end
    end
  end

  assign blk.blk_ready  = r_blk_ready;
  assign process_en     = r_process_en;
  assign sel_type       = r_sel_type;
  assign data_length    = r_data_length;
  assign data_position  = r_data_position;
  assign data           = r_data;
  assign state_sel      = r_state_sel;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule
